hanoi_move_sequencer: RTL and testbench

- Upstream stimulus stage for move_disk. Generates the optimal 2^N-1 move sequence that carries an N-disk tower from rod 0 to a selected target rod.
- Drives move_disk's from_rod/to_rod inputs directly, one move per accepted handshake.
- When idle, drives out-of-range rod codes so that move_disk's legality check treats the cycle as a no-op.

---
 rtl/hanoi_move_sequencer_if.sv | 37 +++
 rtl/hanoi_move_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_hanoi_move_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hanoi_move_sequencer_if.sv
// ---------------------------------------------------------------------------
// hanoi_move_sequencer_if
// Move handshake between the Tower-of-Hanoi move sequencer and its consumer
// (typically move_disk).
//   move_valid  : from_rod/to_rod/move_count describe a move on offer
//   move_ready  : consumer accepts the move on the current rising edge
//   from_rod    : source rod of the offered move
//   to_rod      : destination rod of the offered move
//   move_count  : 1-based index of the offered move, 0 when idle
// Modports: master = move producer (sequencer), slave = move consumer.
// ---------------------------------------------------------------------------
interface hanoi_move_sequencer_if #(
    parameter int RODS_LOG2       = 2,
    parameter int NUMBER_OF_DISKS = 4
);
    logic                       move_valid;
    logic                       move_ready;
    logic [RODS_LOG2-1:0]       from_rod;
    logic [RODS_LOG2-1:0]       to_rod;
    logic [NUMBER_OF_DISKS-1:0] move_count;

    modport master (
        output move_valid,
        output from_rod,
        output to_rod,
        output move_count,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  from_rod,
        input  to_rod,
        input  move_count,
        output move_ready
    );
endinterface

// File: rtl/hanoi_move_sequencer.sv
// ---------------------------------------------------------------------------
// hanoi_move_sequencer
// Emits the optimal 2^N-1 move sequence that carries an N-disk tower from
// rod 0 to TARGET_ROD, one move per accepted handshake. While idle the rod
// outputs carry the out-of-range code 3 so a downstream move_disk treats the
// cycle as a no-op.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : begin a sequence (sampled in IDLE only)
//   abort  : stop the sequence and return to IDLE without a done pulse
//   mv     : move handshake (master side): move_valid, move_ready,
//            from_rod, to_rod, move_count
//   busy   : high while moves are being issued
//   done   : one-cycle pulse after the last move is accepted
// All outputs are registered.
// ---------------------------------------------------------------------------
module hanoi_move_sequencer #(
    parameter int NUMBER_OF_RODS  = 3,
    parameter int NUMBER_OF_DISKS = 4,
    parameter int TARGET_ROD      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    hanoi_move_sequencer_if.master        mv,
    output logic                          busy,
    output logic                          done
);
    localparam int RODS_LOG2 = $clog2(NUMBER_OF_RODS);
    localparam int CW        = NUMBER_OF_DISKS + 1;

    localparam logic [NUMBER_OF_DISKS-1:0] FIRST_MOVE = NUMBER_OF_DISKS'(1);
    localparam logic [NUMBER_OF_DISKS-1:0] LAST_MOVE  = '1;
    localparam logic [RODS_LOG2-1:0]       IDLE_ROD   = '1;

    // The raw closed-form sequence parks the tower on rod 2 for odd N and on
    // rod 1 for even N; relabelling rods 1<->2 retargets it.
    localparam int NATURAL_ROD = ((NUMBER_OF_DISKS % 2) == 1) ? 2 : 1;
    localparam bit SWAP_RODS   = (NATURAL_ROD != TARGET_ROD);

    generate
        if (NUMBER_OF_RODS != 3) begin : g_bad_rods
            $error("hanoi_move_sequencer: NUMBER_OF_RODS must be 3");
        end
        if (NUMBER_OF_DISKS < 1 || NUMBER_OF_DISKS > 15) begin : g_bad_disks
            $error("hanoi_move_sequencer: NUMBER_OF_DISKS must be 1..15");
        end
        if (TARGET_ROD != 1 && TARGET_ROD != 2) begin : g_bad_target
            $error("hanoi_move_sequencer: TARGET_ROD must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       valid_q, valid_d;
    logic [RODS_LOG2-1:0]       from_q, from_d;
    logic [RODS_LOG2-1:0]       to_q, to_d;
    logic [NUMBER_OF_DISKS-1:0] count_q, count_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [NUMBER_OF_DISKS-1:0] next_m;

    function automatic logic [RODS_LOG2-1:0] mod3(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v % CW'(3);
        return r[RODS_LOG2-1:0];
    endfunction

    function automatic logic [RODS_LOG2-1:0] relabel(input logic [RODS_LOG2-1:0] r);
        logic [RODS_LOG2-1:0] o;
        o = r;
        if (SWAP_RODS) begin
            if (r == RODS_LOG2'(1)) begin
                o = RODS_LOG2'(2);
            end else if (r == RODS_LOG2'(2)) begin
                o = RODS_LOG2'(1);
            end
        end
        return o;
    endfunction

    // Move m goes from (m & (m-1)) mod 3; one extra bit keeps m|(m-1)+1 from
    // overflowing at m = 2^N-1.
    function automatic logic [RODS_LOG2-1:0] rod_from(input logic [NUMBER_OF_DISKS-1:0] m);
        logic [CW-1:0] mw;
        mw = CW'(m);
        return relabel(mod3(mw & (mw - CW'(1))));
    endfunction

    // Move m goes to ((m | (m-1)) + 1) mod 3.
    function automatic logic [RODS_LOG2-1:0] rod_to(input logic [NUMBER_OF_DISKS-1:0] m);
        logic [CW-1:0] mw;
        mw = CW'(m);
        return relabel(mod3((mw | (mw - CW'(1))) + CW'(1)));
    endfunction

    assign next_m = count_q + NUMBER_OF_DISKS'(1);

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so every port comes straight from a flop. The terminal move is detected
    // before incrementing, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        from_d  = from_q;
        to_d    = to_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                from_d  = IDLE_ROD;
                to_d    = IDLE_ROD;
                count_d = '0;
                busy_d  = 1'b0;
                if (start && !abort) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    count_d = FIRST_MOVE;
                    from_d  = rod_from(FIRST_MOVE);
                    to_d    = rod_to(FIRST_MOVE);
                    busy_d  = 1'b1;
                end
            end

            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    from_d  = IDLE_ROD;
                    to_d    = IDLE_ROD;
                    count_d = '0;
                    busy_d  = 1'b0;
                end else if (valid_q && mv.move_ready) begin
                    if (count_q == LAST_MOVE) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        from_d  = IDLE_ROD;
                        to_d    = IDLE_ROD;
                        count_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = next_m;
                        from_d  = rod_from(next_m);
                        to_d    = rod_to(next_m);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                from_d  = IDLE_ROD;
                to_d    = IDLE_ROD;
                count_d = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                from_d  = IDLE_ROD;
                to_d    = IDLE_ROD;
                count_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            from_q  <= IDLE_ROD;
            to_q    <= IDLE_ROD;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            from_q  <= from_d;
            to_q    <= to_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mv.move_valid = valid_q;
    assign mv.from_rod   = from_q;
    assign mv.to_rod     = to_q;
    assign mv.move_count = count_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hanoi_move_sequencer
// Drives three sequencer instances (N=4/target 1, N=4/target 2, N=1/target 1)
// one at a time. Expected moves come from an iterative Tower-of-Hanoi solver
// and are queued when start is driven, then popped as the DUT's moves are
// accepted. A rod model plays the consumer and checks every accepted move.
// ---------------------------------------------------------------------------
module tb_hanoi_move_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic ready;
    int   sel;

    always #5 clk = ~clk;

    hanoi_move_sequencer_if #(.RODS_LOG2(2), .NUMBER_OF_DISKS(4)) ifA ();
    hanoi_move_sequencer_if #(.RODS_LOG2(2), .NUMBER_OF_DISKS(4)) ifB ();
    hanoi_move_sequencer_if #(.RODS_LOG2(2), .NUMBER_OF_DISKS(1)) ifC ();

    logic busyA, busyB, busyC, doneA, doneB, doneC;
    logic startA, startB, startC, abortA, abortB, abortC;

    assign startA = start && (sel == 0);
    assign startB = start && (sel == 1);
    assign startC = start && (sel == 2);
    assign abortA = abort && (sel == 0);
    assign abortB = abort && (sel == 1);
    assign abortC = abort && (sel == 2);
    assign ifA.move_ready = ready && (sel == 0);
    assign ifB.move_ready = ready && (sel == 1);
    assign ifC.move_ready = ready && (sel == 2);

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(4), .TARGET_ROD(1)) dutA (
        .clk(clk), .rst(rst), .start(startA), .abort(abortA),
        .mv(ifA.master), .busy(busyA), .done(doneA)
    );
    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(4), .TARGET_ROD(2)) dutB (
        .clk(clk), .rst(rst), .start(startB), .abort(abortB),
        .mv(ifB.master), .busy(busyB), .done(doneB)
    );
    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(1), .TARGET_ROD(1)) dutC (
        .clk(clk), .rst(rst), .start(startC), .abort(abortC),
        .mv(ifC.master), .busy(busyC), .done(doneC)
    );

    // Observed outputs of whichever instance is currently selected.
    int obsValid, obsFrom, obsTo, obsCount, obsBusy, obsDone;
    always_comb begin
        obsValid = 0; obsFrom = 0; obsTo = 0; obsCount = 0; obsBusy = 0; obsDone = 0;
        case (sel)
            0: begin
                obsValid = int'(ifA.move_valid); obsFrom = int'(ifA.from_rod);
                obsTo = int'(ifA.to_rod); obsCount = int'(ifA.move_count);
                obsBusy = int'(busyA); obsDone = int'(doneA);
            end
            1: begin
                obsValid = int'(ifB.move_valid); obsFrom = int'(ifB.from_rod);
                obsTo = int'(ifB.to_rod); obsCount = int'(ifB.move_count);
                obsBusy = int'(busyB); obsDone = int'(doneB);
            end
            default: begin
                obsValid = int'(ifC.move_valid); obsFrom = int'(ifC.from_rod);
                obsTo = int'(ifC.to_rod); obsCount = int'(ifC.move_count);
                obsBusy = int'(busyC); obsDone = int'(doneC);
            end
        endcase
    end

    typedef struct {
        int from;
        int to;
        int cnt;
    } move_t;

    move_t expQ[$];
    int    rh[3];
    int    rs[3][16];
    int    passCount  = 0;
    int    checkCount = 0;
    int    failCount  = 0;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int s, input logic st, input logic ab, input logic rd);
        sel   = s;
        start = st;
        abort = ab;
        ready = rd;
    endtask

    // Iterative solver: cycle through the three rod pairs, always making the
    // only legal move within the pair.
    task automatic genMoves(input int n, input int target);
        int h[3];
        int s[3][16];
        int pa[3];
        int pb[3];
        int other;
        int a, b, ta, tb, f, t;
        move_t mvx;
        other = 3 - target;
        for (int r = 0; r < 3; r++) h[r] = 0;
        for (int i = 0; i < n; i++) begin
            s[0][i] = n - i;
            h[0] = h[0] + 1;
        end
        if ((n % 2) == 0) begin
            pa[0] = 0; pb[0] = other; pa[1] = 0; pb[1] = target; pa[2] = other; pb[2] = target;
        end else begin
            pa[0] = 0; pb[0] = target; pa[1] = 0; pb[1] = other; pa[2] = target; pb[2] = other;
        end
        for (int m = 1; m < (1 << n); m++) begin
            a  = pa[(m - 1) % 3];
            b  = pb[(m - 1) % 3];
            ta = (h[a] > 0) ? s[a][h[a] - 1] : 99;
            tb = (h[b] > 0) ? s[b][h[b] - 1] : 99;
            if (ta < tb) begin f = a; t = b; end
            else begin f = b; t = a; end
            s[t][h[t]] = s[f][h[f] - 1];
            h[t] = h[t] + 1;
            h[f] = h[f] - 1;
            mvx.from = f; mvx.to = t; mvx.cnt = m;
            expQ.push_back(mvx);
        end
    endtask

    task automatic consumerReset(input int n);
        for (int r = 0; r < 3; r++) rh[r] = 0;
        for (int i = 0; i < n; i++) begin
            rs[0][i] = n - i;
            rh[0] = rh[0] + 1;
        end
    endtask

    task automatic consumerApply(input string tag, input int f, input int t);
        int legal;
        legal = 0;
        if (f >= 0 && f < 3 && t >= 0 && t < 3 && f != t && rh[f] > 0) begin
            if (rh[t] == 0) legal = 1;
            else if (rs[t][rh[t] - 1] > rs[f][rh[f] - 1]) legal = 1;
        end
        checkOutput({tag, " legal move"}, legal, 1);
        if (legal == 1) begin
            rs[t][rh[t]] = rs[f][rh[f] - 1];
            rh[t] = rh[t] + 1;
            rh[f] = rh[f] - 1;
        end
    endtask

    task automatic runSequence(input string tag, input int n, input int target, input int s,
                               input int stallFrom, input int stallTo, input int abortAt,
                               input bit startInDone);
        int validCycles = 0;
        int busyCycles  = 0;
        int doneCount   = 0;
        int doneCycle   = -100;
        int firstValid  = -1;
        int lastValid   = -1;
        int holdM3      = 0;
        int abortCycle  = -100;
        int stallLen;
        int total;
        bit aborted     = 1'b0;
        bit finished    = 1'b0;
        total    = (1 << n) - 1;
        stallLen = (stallTo >= stallFrom) ? (stallTo - stallFrom + 1) : 0;
        expQ.delete();
        genMoves(n, target);
        consumerReset(n);
        @(posedge clk); #1;
        applyStimulus(s, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 80 && !finished; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (obsBusy != 0) busyCycles++;
            if (obsDone != 0) begin
                doneCount++;
                doneCycle = k;
                if (startInDone) start = 1'b1;
            end
            if (aborted && k == abortCycle + 1) begin
                checkOutput({tag, " abort valid"}, obsValid, 0);
                checkOutput({tag, " abort from_rod"}, obsFrom, 3);
                checkOutput({tag, " abort to_rod"}, obsTo, 3);
                checkOutput({tag, " abort move_count"}, obsCount, 0);
                checkOutput({tag, " abort busy"}, obsBusy, 0);
            end
            if (!aborted && doneCount > 0 && k > doneCycle) begin
                checkOutput({tag, " idle valid after done"}, obsValid, 0);
                checkOutput({tag, " idle busy after done"}, obsBusy, 0);
            end
            ready = !(k >= stallFrom && k <= stallTo);
            if (obsValid != 0) begin
                validCycles++;
                if (firstValid < 0) firstValid = k;
                lastValid = k;
                if (obsCount == 3) holdM3++;
                if (abortAt > 0 && obsCount == abortAt && !aborted) begin
                    abort      = 1'b1;
                    ready      = 1'b0;
                    aborted    = 1'b1;
                    abortCycle = k;
                end
                if (expQ.size() == 0) begin
                    checkOutput({tag, " unexpected move_valid"}, obsValid, 0);
                end else begin
                    checkOutput({tag, " from_rod"}, obsFrom, expQ[0].from);
                    checkOutput({tag, " to_rod"}, obsTo, expQ[0].to);
                    checkOutput({tag, " move_count"}, obsCount, expQ[0].cnt);
                    if (ready && !abort) begin
                        consumerApply(tag, obsFrom, obsTo);
                        void'(expQ.pop_front());
                    end
                end
            end
            if (aborted && k >= abortCycle + 5) finished = 1'b1;
            if (!aborted && doneCount > 0 && k >= doneCycle + 2) finished = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        checkOutput({tag, " sequence ended within budget"}, int'(finished), 1);
        if (aborted) begin
            checkOutput({tag, " no done after abort"}, doneCount, 0);
        end else begin
            checkOutput({tag, " first valid latency"}, firstValid, 1);
            checkOutput({tag, " valid cycles"}, validCycles, total + stallLen);
            checkOutput({tag, " busy cycles"}, busyCycles, total + stallLen);
            checkOutput({tag, " done pulses"}, doneCount, 1);
            checkOutput({tag, " done timing"}, doneCycle, lastValid + 1);
            checkOutput({tag, " moves outstanding"}, expQ.size(), 0);
            for (int r = 0; r < 3; r++) begin
                checkOutput({tag, $sformatf(" rod %0d height", r)}, rh[r], (r == target) ? n : 0);
            end
            for (int i = 0; i < n && i < rh[target]; i++) begin
                checkOutput({tag, $sformatf(" target disk %0d", i)}, rs[target][i], n - i);
            end
            if (stallLen > 0) begin
                checkOutput({tag, " move 3 hold cycles"}, holdM3, 1 + stallLen);
            end
        end
    endtask

    initial begin
        $display("[TB] hanoi_move_sequencer bench starting");
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset move_valid", obsValid, 0);
        checkOutput("reset from_rod", obsFrom, 3);
        checkOutput("reset to_rod", obsTo, 3);
        checkOutput("reset move_count", obsCount, 0);
        checkOutput("reset busy", obsBusy, 0);
        checkOutput("reset done", obsDone, 0);
        rst = 1'b0;

        $display("[TB] N=4 target 1, free-running");
        runSequence("n4t1", 4, 1, 0, 0, -1, 0, 1'b0);

        $display("[TB] N=4 target 2, free-running");
        runSequence("n4t2", 4, 2, 1, 0, -1, 0, 1'b0);

        $display("[TB] N=4 target 1, backpressure on cycles 3-5");
        runSequence("stall", 4, 1, 0, 3, 5, 0, 1'b0);

        $display("[TB] N=4 target 1, abort at move 7");
        runSequence("abort", 4, 1, 0, 0, -1, 7, 1'b0);

        $display("[TB] restart after abort");
        runSequence("restart", 4, 1, 0, 0, -1, 0, 1'b0);

        $display("[TB] reset mid-sequence");
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid-sequence valid before reset", obsValid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid reset move_valid", obsValid, 0);
        checkOutput("mid reset from_rod", obsFrom, 3);
        checkOutput("mid reset to_rod", obsTo, 3);
        checkOutput("mid reset move_count", obsCount, 0);
        checkOutput("mid reset busy", obsBusy, 0);
        checkOutput("mid reset done", obsDone, 0);
        rst = 1'b0;

        $display("[TB] N=1 target 1, start held during DONE");
        runSequence("n1", 1, 1, 2, 0, -1, 0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
